// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer and its raster counter.
package frame_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    RUN       = 3'd2,
    WRITE     = 3'd3,
    FRAME_END = 3'd4
  } seq_state_t;

  localparam int unsigned WIDTH_DEF   = 160;
  localparam int unsigned HEIGHT_DEF  = 120;
  localparam logic [23:0] ERR_RGB_DEF = 24'hFF00FF;
  localparam int unsigned FB_ADDR_W   = 15;

endpackage

// File: rtl/raster_counter.sv
// Raster position counters: column, row and linear address advanced together.
module raster_counter
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned Width  = WIDTH_DEF,
  parameter int unsigned Height = HEIGHT_DEF,
  parameter int unsigned AddrW  = FB_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [31:0]      x,
  output logic [31:0]      y,
  output logic [AddrW-1:0] addr,
  output logic             last
);

  assign last = (x == Width - 1) && (y == Height - 1);

  // The address tracks y*Width+x by counting alongside x/y, so no multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance && !last) begin
      if (x == Width - 1) begin
        x <= '0;
        y <= y + 32'd1;
      end else begin
        x <= x + 32'd1;
      end
      addr <= addr + AddrW'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Walks every pixel of a frame, runs the shader per pixel and writes its colour.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned Width   = WIDTH_DEF,
  parameter int unsigned Height  = HEIGHT_DEF,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [23:0] ERR_RGB = ERR_RGB_DEF
) (
  input  logic                 clk,
  input  logic                 start,
  input  logic                 go,
  output logic [31:0]          pixel_x,
  output logic [31:0]          pixel_y,
  output logic                 shader_start,
  input  logic [23:0]          shader_rgb,
  input  logic                 shader_done,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [23:0]          fb_data,
  output logic                 frame_begin,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic [15:0]          timeout_count
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t      state;
  logic [CntW-1:0] wait_cnt;
  logic            raster_clear;
  logic            raster_advance;
  logic            raster_last;

  // Position resets as the FSM leaves IDLE/FRAME_END for a new frame.
  always_comb begin
    raster_clear   = go && ((state == IDLE) || (state == FRAME_END));
    raster_advance = (state == WRITE);
  end

  raster_counter #(
    .Width (Width),
    .Height(Height),
    .AddrW (FB_ADDR_W)
  ) u_raster (
    .clk    (clk),
    .rst_n  (start),
    .clear  (raster_clear),
    .advance(raster_advance),
    .x      (pixel_x),
    .y      (pixel_y),
    .addr   (fb_addr),
    .last   (raster_last)
  );

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      shader_start  <= 1'b0;
      fb_we         <= 1'b0;
      fb_data       <= '0;
      frame_begin   <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      timeout_count <= '0;
    end else begin
      fb_we       <= 1'b0;
      frame_begin <= 1'b0;
      frame_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state        <= ISSUE;
            frame_begin  <= 1'b1;
            shader_start <= 1'b0;
          end
        end
        ISSUE: begin
          state        <= RUN;
          shader_start <= 1'b1;
          wait_cnt     <= '0;
        end
        RUN: begin
          // Done on the final wait cycle still beats the timeout.
          if (shader_done) begin
            fb_data <= shader_rgb;
            fb_we   <= 1'b1;
            state   <= WRITE;
          end else if (wait_cnt == CntW'(TIMEOUT - 1)) begin
            fb_data <= ERR_RGB;
            fb_we   <= 1'b1;
            state   <= WRITE;
            if (timeout_count != '1) timeout_count <= timeout_count + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + CntW'(1);
          end
        end
        WRITE: begin
          if (raster_last) begin
            state       <= FRAME_END;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end else begin
            state        <= ISSUE;
            shader_start <= 1'b0;
          end
        end
        FRAME_END: begin
          if (go) begin
            state        <= ISSUE;
            frame_begin  <= 1'b1;
            shader_start <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench: table-driven first pixels, then randomized shader latency vs a pixel-index model.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int unsigned W    = 12;
  localparam int unsigned H    = 4;
  localparam int unsigned T    = 64;
  localparam logic [23:0] ERR  = 24'hFF00FF;
  localparam int          NPIX = W * H;

  logic                 clk = 1'b0;
  logic                 start = 1'b0;
  logic                 go = 1'b0;
  logic                 shader_done = 1'b0;
  logic [23:0]          shader_rgb = '0;
  logic [31:0]          pixel_x, pixel_y;
  logic                 shader_start, fb_we, frame_begin, frame_done;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [23:0]          fb_data;
  logic [15:0]          frame_count, timeout_count;

  always #5 clk = ~clk;

  frame_sequencer #(
    .Width  (W),
    .Height (H),
    .TIMEOUT(T),
    .ERR_RGB(ERR)
  ) dut (
    .clk          (clk),
    .start        (start),
    .go           (go),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .shader_start (shader_start),
    .shader_rgb   (shader_rgb),
    .shader_done  (shader_done),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .frame_begin  (frame_begin),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .timeout_count(timeout_count)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: pixel index p in raster order, plus expected event cycles.
  int          p;
  bit          model_idle;
  int          exp_fd_cyc, exp_fb_cyc, exp_frames;
  logic [15:0] exp_to;
  int          issue_cyc, low_cnt, last_gap;
  int          sh_cnt, sh_lat, next_lat;
  bit          rand_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 0;
    if (r == 1) return int'(T);
    if (r == 2) return int'(T) + 1;
    return (r % 8) + 1;
  endfunction

  always @(negedge clk) begin
    int  k;
    bit  err;
    cyc++;
    if (!start) begin
      p = 0; model_idle = 1'b1; exp_fd_cyc = -1; exp_fb_cyc = -1;
      exp_frames = 0; exp_to = '0; low_cnt = 0; sh_cnt = 0;
      shader_done = 1'b0;
    end else begin
      if (model_idle && (fb_we || frame_begin || frame_done))
        check("idle_quiet", {fb_we, frame_begin, frame_done}, 0);
      if (model_idle && go) begin
        model_idle = 1'b0; exp_fb_cyc = cyc + 1; p = 0;
      end
      if (frame_begin || cyc == exp_fb_cyc) begin
        check("frame_begin", frame_begin, cyc == exp_fb_cyc);
        check("begin_xy", {pixel_x, pixel_y}, 0);
        check("begin_addr", fb_addr, 0);
        low_cnt = 0;
      end
      if (fb_we) begin
        if (p >= NPIX) begin
          check("extra_write", fb_addr, 0);
        end else begin
          err = !(sh_lat >= 1 && sh_lat <= int'(T));
          k   = err ? int'(T) : sh_lat;
          if (err && exp_to != 16'hFFFF) exp_to = exp_to + 16'd1;
          last_gap = cyc - issue_cyc;
          check("wr_addr", fb_addr, p);
          check("wr_xy", {pixel_x, pixel_y}, {32'(p % W), 32'(p / W)});
          check("wr_data", fb_data, err ? ERR : {8'(p % W), 8'(p / W), 8'h5A});
          check("wr_gap", last_gap, 1 + k);
          check("issue_low_cycles", low_cnt, 1);
          check("timeout_count", timeout_count, exp_to);
          low_cnt = 0;
          if (p == NPIX - 1) exp_fd_cyc = cyc + 1;
          p++;
        end
      end
      if (frame_done || cyc == exp_fd_cyc) begin
        check("frame_done", frame_done, cyc == exp_fd_cyc);
        if (cyc == exp_fd_cyc) begin
          exp_frames++;
          check("frame_count", frame_count, 16'(exp_frames));
          if (go) begin exp_fb_cyc = cyc + 1; p = 0; end
          else model_idle = 1'b1;
        end
      end
      // Shader model: cleared while start is low, done after sh_lat running cycles.
      if (!shader_start) begin
        sh_cnt = 0; shader_done = 1'b0; issue_cyc = cyc; low_cnt++;
        sh_lat = rand_mode ? pick_lat() : next_lat;
      end else begin
        sh_cnt++;
        if (sh_lat != 0 && sh_cnt >= sh_lat) shader_done = 1'b1;
      end
      shader_rgb = {pixel_x[7:0], pixel_y[7:0], 8'h5A};
    end
  end

  typedef struct {
    int          lat;
    int          exp_gap;
    logic [23:0] exp_data;
    logic [15:0] exp_to;
  } vec_t;

  vec_t vec[9];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_xy"}, {pixel_x, pixel_y}, 0);
    check({tag, "_addr"}, fb_addr, 0);
    check({tag, "_data"}, fb_data, 0);
    check({tag, "_counts"}, {frame_count, timeout_count}, 0);
    check({tag, "_strobes"}, {shader_start, fb_we, frame_begin, frame_done}, 0);
  endtask

  task automatic wait_frame_done(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < budget) begin @(negedge clk); n++; end
    check(name, frame_done, 1);
  endtask

  initial begin
    int n, wr;
    // lat 0 = shader never answers; T = done on the timeout cycle; T+1 = just too late
    vec[0] = '{5,  6,  24'h00005A, 16'd0};
    vec[1] = '{5,  6,  24'h01005A, 16'd0};
    vec[2] = '{5,  6,  24'h02005A, 16'd0};
    vec[3] = '{5,  6,  24'h03005A, 16'd0};
    vec[4] = '{1,  2,  24'h04005A, 16'd0};
    vec[5] = '{64, 65, 24'h05005A, 16'd0};
    vec[6] = '{65, 65, 24'hFF00FF, 16'd1};
    vec[7] = '{0,  65, 24'hFF00FF, 16'd2};
    vec[8] = '{3,  4,  24'h08005A, 16'd2};

    next_lat = 5;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("idle_hold", {frame_begin, shader_start, fb_we}, 0);
    next_lat = vec[0].lat;
    go = 1'b1;

    for (int i = 0; i < 9; i++) begin
      n = 0;
      @(negedge clk);
      while (!fb_we && n < 300) begin @(negedge clk); n++; end
      check("vec_write_seen", fb_we, 1);
      #1;
      check("vec_addr", fb_addr, i);
      check("vec_data", fb_data, vec[i].exp_data);
      check("vec_gap", last_gap, vec[i].exp_gap);
      check("vec_timeouts", timeout_count, vec[i].exp_to);
      if (i < 8) next_lat = vec[i + 1].lat;
      else rand_mode = 1'b1;
    end

    wait_frame_done("frame1_done", 6000);
    #1 check("frame1_count", frame_count, 1);
    wait_frame_done("frame2_done", 6000);
    #1 check("frame2_count", frame_count, 2);

    // Abandon pixel (10,2) mid-RUN with an asynchronous reset.
    n = 0;
    @(negedge clk);
    while (!(pixel_x == 10 && pixel_y == 2 && shader_start && !fb_we) && n < 6000) begin
      @(negedge clk); n++;
    end
    check("reach_pixel_10_2", {pixel_x, pixel_y}, {32'd10, 32'd2});
    #1 start = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!frame_begin && n < 20) begin @(negedge clk); n++; end
    check("restart_begin", frame_begin, 1);
    check("restart_addr", fb_addr, 0);

    // Drop go mid-frame: the frame completes, then the sequencer idles.
    n = 0;
    @(negedge clk);
    while (pixel_y != 2 && n < 6000) begin @(negedge clk); n++; end
    check("reach_row_2", pixel_y, 2);
    @(posedge clk);
    #1 go = 1'b0;
    wait_frame_done("stop_frame_done", 6000);
    #1 check("stop_frame_count", frame_count, 1);
    wr = 0;
    repeat (150) begin
      @(negedge clk);
      if (fb_we || frame_begin) wr++;
    end
    check("quiet_after_stop", wr, 0);
    check("final_timeouts", timeout_count, exp_to);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Initiator for pixel_shader: walks every pixel of a Width x Height frame and issues coordinates to the shader.
- Cycles the shader's active-low start per pixel, waits for its done, and writes the returned RGB into the framebuffer write port.
- Sits between the top level (SW/randvals source) and the shader/framebuffer pair.
- Pulses frame_begin so upstream can refresh randvals once per frame.

Parameters:
- Width, 160, pixels per row.
- Height, 120, rows per frame.
- TIMEOUT, 64, max RUN cycles before a pixel is abandoned.
- ERR_RGB, 24'hFF00FF, colour written on timeout.

Ports:
- clk  in  1  system clock, all state on posedge.
- start  in  1  async active-low reset (0 reset, 1 drawing); same meaning as the shader's start.
- go  in  1  level; 1 = render frames back-to-back, 0 = stop after current frame.
- pixel_x  out  32  current column 0..Width-1, to shader uncorrected_x.
- pixel_y  out  32  current row 0..Height-1, to shader uncorrected_y.
- shader_start  out  1  to shader start; 0 clears shader, 1 runs it.
- shader_rgb  in  24  shader outRGB.
- shader_done  in  1  shader done.
- fb_we  out  1  framebuffer write strobe, one cycle per pixel.
- fb_addr  out  15  y*Width+x.
- fb_data  out  24  RGB to write.
- frame_begin  out  1  one-cycle pulse at the start of each frame.
- frame_done  out  1  one-cycle pulse after the last pixel's write.
- frame_count  out  16  completed frames, wraps at 65535->0.
- timeout_count  out  16  pixels abandoned since reset, saturates at 16'hFFFF.

Behaviour:
- Reset (start=0, async): state IDLE; every output 0 (pixel_x, pixel_y, fb_addr, fb_data, frame_count, timeout_count, shader_start, fb_we, frame_begin, frame_done). Asserting start low mid-pixel abandons the pixel; no write occurs.
- States: IDLE, ISSUE, RUN, WRITE, FRAME_END.
- IDLE:
  - go=1 -> ISSUE with x=y=addr=0 and frame_begin=1 for that transition cycle.
  - go=0 -> stay.
- ISSUE: shader_start=0 for exactly one cycle; pixel_x/pixel_y already hold the new coordinate -> RUN.
- RUN:
  - shader_start=1; pixel_x/pixel_y/fb_addr held stable for the whole RUN.
  - Wait counter starts at 0 and increments each cycle.
  - shader_done=1 sampled -> capture shader_rgb into fb_data -> WRITE.
  - Counter reaches TIMEOUT-1 without done -> fb_data=ERR_RGB, timeout_count+1 (saturating) -> WRITE.
  - Done arriving on the same cycle as the timeout is treated as done; shader data wins.
- WRITE: fb_we=1 exactly one cycle, with fb_addr/fb_data valid on that cycle. The same edge advances the position:
  - x<Width-1: x+1, addr+1 -> ISSUE.
  - x=Width-1 and y<Height-1: x=0, y+1, addr+1 -> ISSUE.
  - Last pixel (x=Width-1, y=Height-1): -> FRAME_END.
- FRAME_END:
  - frame_done=1 for one cycle; frame_count+1.
  - go=1: x=y=addr=0, frame_begin=1 -> ISSUE.
  - go=0: -> IDLE, holding the last coordinates.
- Addressing: fb_addr is an incrementing counter, not a multiplier; it equals y*Width+x at all times outside reset. Max value Width*Height-1 = 19199, which fits 15 bits.
- Pixel period: 1 (ISSUE) + k (RUN, k = cycles until done is sampled, 1..TIMEOUT) + 1 (WRITE).
  - Against the shader, done is visible 4 edges after shader_start rises, so k=5 and the period is 7 cycles.
  - Full frame = 19200*7 + 1 = 134401 cycles from frame_begin to frame_done.
- go falling mid-frame has no effect until FRAME_END; the frame always completes.
- shader_done already 1 on entry to RUN is not possible: ISSUE clears the shader. Done is only honoured in RUN.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, ISSUE=1, RUN=2, WRITE=3, FRAME_END=4);
  - Width/Height defaults;
  - ERR_RGB;
  - FB_ADDR_W=15.
- One natural sub-module: raster_counter (x/y/addr counters with advance, clear and last-pixel flag), reusable by a future framebuffer scan-out reader.

Test Plan:
- Reset then go=1, model shader with done 4 edges after start rises, rgb={x[7:0],y[7:0],8'h5A} -> fb_we pulses at cycles 7n+7; pixel (3,0) written at addr 3 with data 24'h03005A; shader_start low exactly 1 cycle per pixel.
- Row wrap, Width=160: after pixel (159,0) -> next ISSUE shows x=0, y=1, fb_addr=160.
- Frame end, Width=4, Height=2, go held 1 -> frame_done once after the write at addr 7; frame_count=1; frame_begin on the next cycle with addr 0; second frame identical.
- Timeout, TIMEOUT=64, shader never asserts done -> fb_we after 64 RUN cycles, fb_data=24'hFF00FF, timeout_count=1; next pixel proceeds normally.
- Reset mid-RUN at pixel (10,2): pulse start=0 asynchronously -> all outputs 0 immediately, no fb_we; after release with go=1, rendering restarts at (0,0) with frame_begin.
- go dropped during row 50 -> frame finishes, frame_done pulses, FSM enters IDLE, no further fb_we or frame_begin.
